// File: rtl/wam_pkg.sv
// Shared constants for the Whack-a-Mole game core: state encoding, hole
// count, keypad position width and the hole-picker LFSR seed/taps.
package wam_pkg;

   localparam int unsigned NUM_HOLES = 9;
   localparam int unsigned POS_W     = 4;
   localparam int unsigned STATE_W   = 2;

   localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
   localparam logic [STATE_W-1:0] ST_GAP  = 2'd1;
   localparam logic [STATE_W-1:0] ST_UP   = 2'd2;
   localparam logic [STATE_W-1:0] ST_OVER = 2'd3;

   // x^8 + x^6 + x^5 + x^4 + 1, shifting left: feedback from bits 7,5,4,3
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   // One-hot hole vector for a hole index (index must be < NUM_HOLES)
   function automatic logic [NUM_HOLES-1:0] hole_onehot(input logic [POS_W-1:0] h);
      logic [NUM_HOLES-1:0] one;
      one = NUM_HOLES'(1);
      return one << h;
   endfunction

endpackage

// File: rtl/mole_game_core_lfsr_picker.sv
// lfsr_picker: free-running 8-bit Fibonacci LFSR that supplies the next
// mole hole. A candidate register keeps the latest in-range LFSR nibble;
// the offered hole is bumped by one (mod NUM_HOLES) when it would repeat
// the hole taken last, so consecutive moles never share a hole.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   take       : strobe, the current hole is being used for a new mole
//   hole[3:0]  : registered hole offer, always < NUM_HOLES
module lfsr_picker
   import wam_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             take,
   output logic [POS_W-1:0] hole
);

   logic [7:0]       lfsr;
   logic [POS_W-1:0] cand;
   logic [POS_W-1:0] last;
   logic [POS_W-1:0] sel_c;

   // No-repeat rule applied to the candidate
   always_comb begin
      sel_c = cand;
      if (cand == last) begin
         sel_c = (cand == POS_W'(NUM_HOLES - 1)) ? '0 : cand + POS_W'(1);
      end
   end

   // LFSR advances every cycle; last starts out of range so the first pick is free
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= LFSR_SEED;
         cand <= '0;
         last <= '1;
         hole <= '0;
      end else begin
         lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
         if (lfsr[POS_W-1:0] < POS_W'(NUM_HOLES)) begin
            cand <= lfsr[POS_W-1:0];
         end
         hole <= sel_c;
         if (take) begin
            last <= hole;
         end
      end
   end

endmodule

// File: rtl/mole_game_core.sv
// mole_game_core: Whack-a-Mole game engine. Consumes keypad presses,
// raises one mole at a time, times it, scores hits, counts misses and
// ends the game after MAX_MISSES misses.
// Optional feature: define WAM_SPEEDUP_EN to shorten mole life on each hit.
// Ports:
//   clk, reset        : clock, async active-low reset
//   start             : level, begins a game from IDLE or OVER
//   valid_key         : keypad key-valid level, rising edge = one press
//   position[3:0]     : pressed hole, >= 9 ignored
//   moles[8:0]        : one-hot active mole
//   score[SCORE_W-1:0]: saturating hit count
//   misses[2:0]       : saturating miss count
//   hit_pulse         : one-cycle strobe per hit
//   game_over         : high in OVER
module mole_game_core
   import wam_pkg::*;
#(
   parameter int unsigned TICK_DIV     = 50000,
   parameter int unsigned MOLE_LIFE_MS = 1000,
   parameter int unsigned SPAWN_GAP_MS = 400,
   parameter int unsigned MAX_MISSES   = 5,
   parameter int unsigned SCORE_W      = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 valid_key,
   input  logic [POS_W-1:0]     position,
   output logic [NUM_HOLES-1:0] moles,
   output logic [SCORE_W-1:0]   score,
   output logic [2:0]           misses,
   output logic                 hit_pulse,
   output logic                 game_over
);

   localparam int unsigned TMAX  = (MOLE_LIFE_MS > SPAWN_GAP_MS) ? MOLE_LIFE_MS : SPAWN_GAP_MS;
   localparam int unsigned TIM_W = $clog2(TMAX + 1);
   localparam int unsigned PRE_W = $clog2(TICK_DIV + 1);

   logic                 vk_q, vk_qq;
   logic [POS_W-1:0]     pos_q, pos_r;
   logic                 press_r;
   logic [STATE_W-1:0]   state, state_nxt;
   logic [PRE_W-1:0]     pre_cnt, pre_nxt;
   logic                 tick_c;
   logic [TIM_W-1:0]     timer, timer_nxt;
   logic [NUM_HOLES-1:0] moles_nxt;
   logic [SCORE_W-1:0]   score_nxt;
   logic [2:0]           misses_nxt, misses_inc;
   logic                 hit_nxt;
   logic                 take_c;
   logic [POS_W-1:0]     hole;
   logic                 expire_c;
   logic [TIM_W-1:0]     life_reload;

`ifdef WAM_SPEEDUP_EN
   localparam int unsigned LIFE_STEP  = MOLE_LIFE_MS / 8;
   localparam int unsigned LIFE_FLOOR = MOLE_LIFE_MS / 4;
   logic [TIM_W-1:0] reload_nxt;
`else
   assign life_reload = TIM_W'(MOLE_LIFE_MS);
`endif

   lfsr_picker u_picker (
      .clk   (clk),
      .rst_n (reset),
      .take  (take_c),
      .hole  (hole)
   );

   assign tick_c     = (pre_cnt == PRE_W'(TICK_DIV - 1));
   assign expire_c   = tick_c && (timer <= TIM_W'(1));
   assign misses_inc = (misses < 3'(MAX_MISSES)) ? misses + 3'd1 : misses;

   // Next-state and registered-output values
   always_comb begin
      state_nxt  = state;
      timer_nxt  = timer;
      moles_nxt  = moles;
      score_nxt  = score;
      misses_nxt = misses;
      hit_nxt    = 1'b0;
      take_c     = 1'b0;
`ifdef WAM_SPEEDUP_EN
      reload_nxt = life_reload;
`endif
      case (state)
         ST_IDLE, ST_OVER: begin
            moles_nxt = '0;
            if (start) begin
               state_nxt  = ST_GAP;
               score_nxt  = '0;
               misses_nxt = '0;
               timer_nxt  = TIM_W'(SPAWN_GAP_MS);
`ifdef WAM_SPEEDUP_EN
               reload_nxt = TIM_W'(MOLE_LIFE_MS);
`endif
            end
         end
         ST_GAP: begin
            if (tick_c) begin
               if (timer <= TIM_W'(1)) begin
                  state_nxt = ST_UP;
                  take_c    = 1'b1;
                  moles_nxt = hole_onehot(hole);
                  timer_nxt = life_reload;
               end else begin
                  timer_nxt = timer - TIM_W'(1);
               end
            end
         end
         ST_UP: begin
            if (tick_c) begin
               timer_nxt = timer - TIM_W'(1);
            end
            // A hit outranks an expiry landing in the same cycle
            if (press_r && (hole_onehot(pos_r) == moles)) begin
               if (score != '1) begin
                  score_nxt = score + SCORE_W'(1);
               end
               hit_nxt   = 1'b1;
               moles_nxt = '0;
               state_nxt = ST_GAP;
               timer_nxt = TIM_W'(SPAWN_GAP_MS);
`ifdef WAM_SPEEDUP_EN
               reload_nxt = (life_reload >= TIM_W'(LIFE_FLOOR + LIFE_STEP)) ?
                            life_reload - TIM_W'(LIFE_STEP) : TIM_W'(LIFE_FLOOR);
`endif
            end else if (press_r || expire_c) begin
               misses_nxt = misses_inc;
               if (expire_c) begin
                  moles_nxt = '0;
                  state_nxt = ST_GAP;
                  timer_nxt = TIM_W'(SPAWN_GAP_MS);
               end
               if (misses_inc >= 3'(MAX_MISSES)) begin
                  moles_nxt = '0;
                  state_nxt = ST_OVER;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            moles_nxt = '0;
         end
      endcase
      // Prescaler restarts on every state change so durations are whole ticks
      if (state_nxt != state || tick_c) begin
         pre_nxt = '0;
      end else begin
         pre_nxt = pre_cnt + PRE_W'(1);
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Press pipeline, timers and outputs; press is registered once more so
   // the hole compare sees a stable, range-filtered event
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vk_q      <= 1'b0;
         vk_qq     <= 1'b0;
         pos_q     <= '0;
         press_r   <= 1'b0;
         pos_r     <= '0;
         pre_cnt   <= '0;
         timer     <= '0;
         moles     <= '0;
         score     <= '0;
         misses    <= '0;
         hit_pulse <= 1'b0;
         game_over <= 1'b0;
      end else begin
         vk_q      <= valid_key;
         vk_qq     <= vk_q;
         pos_q     <= position;
         press_r   <= vk_q && !vk_qq && (pos_q < POS_W'(NUM_HOLES));
         pos_r     <= pos_q;
         pre_cnt   <= pre_nxt;
         timer     <= timer_nxt;
         moles     <= moles_nxt;
         score     <= score_nxt;
         misses    <= misses_nxt;
         hit_pulse <= hit_nxt;
         game_over <= (state_nxt == ST_OVER);
      end
   end

`ifdef WAM_SPEEDUP_EN
   // Mole life reload, shortened by hits
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         life_reload <= TIM_W'(MOLE_LIFE_MS);
      end else begin
         life_reload <= reload_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_mole_game_core.sv
// Directed bench for mole_game_core with a fast timebase:
// TICK_DIV=10, MOLE_LIFE_MS=5, SPAWN_GAP_MS=3, MAX_MISSES=2.
// Gap = 30 cycles, mole life = 50 cycles; a press acts 2 edges after the
// edge that first samples valid_key high.
module tb_mole_game_core;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       valid_key;
   logic [3:0] position;
   logic [8:0] moles;
   logic [7:0] score;
   logic [2:0] misses;
   logic       hit_pulse;
   logic       game_over;

   int n_cmp = 0;
   int n_err = 0;

   mole_game_core #(
      .TICK_DIV     (10),
      .MOLE_LIFE_MS (5),
      .SPAWN_GAP_MS (3),
      .MAX_MISSES   (2),
      .SCORE_W      (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .valid_key (valid_key),
      .position  (position),
      .moles     (moles),
      .score     (score),
      .misses    (misses),
      .hit_pulse (hit_pulse),
      .game_over (game_over)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance n clock edges, landing 1 time unit after the last one
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Cycles until moles becomes non-zero (up=1) or zero (up=0), bounded
   task automatic wait_moles(input bit up, output int cyc);
      cyc = 0;
      do begin
         step(1);
         cyc++;
      end while (((moles != 9'd0) != up) && cyc < 500);
   endtask

   function automatic int hole_of(input logic [8:0] m);
      for (int i = 0; i < 9; i++) begin
         if (m[i]) return i;
      end
      return 15;
   endfunction

   function automatic logic [3:0] other_hole(input int h);
      return (h == 8) ? 4'd0 : 4'(h + 1);
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   int c, h1, h2, h3, h4, h5, h6, hp_cnt;
   logic [8:0] exp_m;

   initial begin
      reset = 1'b0; start = 1'b0; valid_key = 1'b0; position = 4'd0;
      step(2);
      check("rst_moles",  32'(moles), 0);
      check("rst_score",  32'(score), 0);
      check("rst_misses", 32'(misses), 0);
      check("rst_hit",    32'(hit_pulse), 0);
      check("rst_over",   32'(game_over), 0);
      reset = 1'b1;
      step(2);
      check("idle_moles", 32'(moles), 0);

      // First mole: rises 30 cycles after GAP entry
      pulse_start();
      wait_moles(1'b1, c);
      check("gap_len", 32'(c), 30);
      check("onehot", 32'($onehot(moles)), 1);
      h1 = hole_of(moles);
      check("hole_range", 32'(h1 < 9), 1);

      // Hit: hit_pulse on the 2nd edge after the sampling edge, one cycle wide
      valid_key = 1'b1; position = 4'(h1);
      step(2);
      check("hit_early", 32'(hit_pulse), 0);
      check("mole_still_up", 32'(moles != 9'd0), 1);
      step(1);
      check("hit_pulse", 32'(hit_pulse), 1);
      check("hit_moles", 32'(moles), 0);
      check("hit_score", 32'(score), 1);
      valid_key = 1'b0;
      step(1);
      check("hit_one_cycle", 32'(hit_pulse), 0);

      // Next mole: already one edge into the gap
      wait_moles(1'b1, c);
      check("gap_after_hit", 32'(c), 29);
      h2 = hole_of(moles);
      check("no_repeat_1", 32'(h2 != h1), 1);

      // Expiry with no press
      wait_moles(1'b0, c);
      check("life_len", 32'(c), 50);
      check("expire_misses", 32'(misses), 1);
      check("expire_score", 32'(score), 1);
      wait_moles(1'b1, c);
      check("gap_after_miss", 32'(c), 30);
      h3 = hole_of(moles);
      check("no_repeat_2", 32'(h3 != h2), 1);

      // Wrong hole reaches MAX_MISSES -> OVER
      valid_key = 1'b1; position = other_hole(h3);
      step(3);
      valid_key = 1'b0;
      check("wrong_misses", 32'(misses), 2);
      check("over_flag", 32'(game_over), 1);
      check("over_moles", 32'(moles), 0);
      check("over_score_held", 32'(score), 1);

      // Restart clears score and misses
      pulse_start();
      check("restart_score", 32'(score), 0);
      check("restart_misses", 32'(misses), 0);
      check("restart_over", 32'(game_over), 0);

      // Wrong press (1 miss, mole stays), then expiry (2nd miss) -> OVER
      wait_moles(1'b1, c);
      h4 = hole_of(moles);
      exp_m = 9'b1 << h4;
      valid_key = 1'b1; position = other_hole(h4);
      step(3);
      valid_key = 1'b0;
      check("wrong1_misses", 32'(misses), 1);
      check("wrong1_mole_stays", 32'(moles), 32'(exp_m));
      check("wrong1_not_over", 32'(game_over), 0);
      wait_moles(1'b0, c);
      check("expire_after_wrong", 32'(c), 47);
      check("expire2_misses", 32'(misses), 2);
      check("expire2_over", 32'(game_over), 1);
      pulse_start();
      check("restart2_score", 32'(score), 0);
      check("restart2_misses", 32'(misses), 0);

      // Out-of-range position has no effect
      wait_moles(1'b1, c);
      h5 = hole_of(moles);
      valid_key = 1'b1; position = 4'd12;
      step(3);
      valid_key = 1'b0;
      check("pos12_score", 32'(score), 0);
      check("pos12_misses", 32'(misses), 0);
      check("pos12_mole_up", 32'(moles != 9'd0), 1);
      step(1);

      // Held key on the right hole: one hit only. The following mole
      // (rising 30 cycles after the hit) expires inside the window: 1 miss.
      valid_key = 1'b1; position = 4'(h5);
      hp_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         step(1);
         hp_cnt += int'(hit_pulse);
      end
      valid_key = 1'b0;
      check("held_hits", 32'(hp_cnt), 1);
      check("held_score", 32'(score), 1);
      check("held_misses", 32'(misses), 1);

      // Hit acting exactly on the expiry edge (rise + 50)
      wait_moles(1'b1, c);
      h6 = hole_of(moles);
      step(47);
      valid_key = 1'b1; position = 4'(h6);
      step(3);
      valid_key = 1'b0;
      check("edge_hit_score", 32'(score), 2);
      check("edge_hit_misses", 32'(misses), 1);
      check("edge_hit_pulse", 32'(hit_pulse), 1);
      check("edge_hit_moles", 32'(moles), 0);
      check("edge_hit_not_over", 32'(game_over), 0);

      // Asynchronous reset mid-UP
      wait_moles(1'b1, c);
      step(5);
      #2;
      reset = 1'b0;
      #1;
      check("async_moles", 32'(moles), 0);
      check("async_score", 32'(score), 0);
      check("async_misses", 32'(misses), 0);
      check("async_hit", 32'(hit_pulse), 0);
      check("async_over", 32'(game_over), 0);
      reset = 1'b1;
      step(40);
      check("post_reset_idle", 32'(moles), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
